// File: rtl/pspin_dma_arb_pkg.sv
// Shared types and constants for the PsPIN host-memory DMA read-descriptor arbiter.
// Used by pspin_hostmem_dma_rd_arb (optional stats: PSPIN_HOSTMEM_DMA_RD_ARB_STATS_EN).
package pspin_dma_arb_pkg;

  localparam int PORT_IDX_WIDTH          = 3;
  localparam int S_TAG_MAX_WIDTH         = 32;
  localparam int DEFAULT_MAX_OUTSTANDING = 16;
  localparam int SLOT_IDX_WIDTH          = $clog2(DEFAULT_MAX_OUTSTANDING);

  localparam logic [3:0] DMA_ERR_NONE         = 4'h0;
  localparam logic [3:0] DMA_ERR_TIMEOUT      = 4'h1;
  localparam logic [3:0] DMA_ERR_PARITY       = 4'h2;
  localparam logic [3:0] DMA_ERR_CPL_ABORT    = 4'h3;
  localparam logic [3:0] DMA_ERR_CPL_UNSUPP   = 4'h4;

  // Tag and port fields are sized for the widest supported requester; narrower
  // configurations zero-extend into them.
  typedef struct packed {
    logic [PORT_IDX_WIDTH-1:0]  port;
    logic [S_TAG_MAX_WIDTH-1:0] s_tag;
    logic                       valid;
  } slot_entry_t;

  function automatic int slot_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pspin_rr_arbiter.sv
// Round-robin arbiter with grant enable; priority starts one past the last granted port.
module pspin_rr_arbiter #(
  parameter int PORTS = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [PORTS-1:0]          req,
  input  logic                      en,
  output logic [PORTS-1:0]          grant,
  output logic [$clog2(PORTS)-1:0]  grant_idx,
  output logic                      grant_valid
);

  localparam int IW = $clog2(PORTS);

  logic [IW-1:0] ptr;

  always_comb begin
    int p;
    p           = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (en) begin
      for (int i = 0; i < PORTS; i++) begin
        p = int'(ptr) + i;
        if (p >= PORTS) p = p - PORTS;
        if (!grant_valid && req[p]) begin
          grant_valid = 1'b1;
          grant[p]    = 1'b1;
          grant_idx   = IW'(p);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IW'(PORTS - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/pspin_hostmem_dma_rd_arb.sv
// Shares one DMA read-descriptor channel among PORTS requesters with slot-tag remapping.
// Optional counters stat_issued/stat_err/stat_drop under PSPIN_HOSTMEM_DMA_RD_ARB_STATS_EN.
module pspin_hostmem_dma_rd_arb
  import pspin_dma_arb_pkg::*;
#(
  parameter int PORTS           = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int RAM_SEL_WIDTH   = 4,
  parameter int RAM_ADDR_WIDTH  = 20,
  parameter int DMA_LEN_WIDTH   = 16,
  parameter int S_TAG_WIDTH     = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int M_TAG_WIDTH     = 16
) (
  input  logic                              clk,
  input  logic                              rstn,

  input  logic [PORTS*ADDR_WIDTH-1:0]       s_axis_read_desc_dma_addr,
  input  logic [PORTS*RAM_SEL_WIDTH-1:0]    s_axis_read_desc_ram_sel,
  input  logic [PORTS*RAM_ADDR_WIDTH-1:0]   s_axis_read_desc_ram_addr,
  input  logic [PORTS*DMA_LEN_WIDTH-1:0]    s_axis_read_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]      s_axis_read_desc_tag,
  input  logic [PORTS-1:0]                  s_axis_read_desc_valid,
  output logic [PORTS-1:0]                  s_axis_read_desc_ready,

  output logic [PORTS*S_TAG_WIDTH-1:0]      m_axis_read_desc_status_tag,
  output logic [PORTS*4-1:0]                m_axis_read_desc_status_error,
  output logic [PORTS-1:0]                  m_axis_read_desc_status_valid,

  output logic [ADDR_WIDTH-1:0]             m_axis_read_desc_dma_addr,
  output logic [RAM_SEL_WIDTH-1:0]          m_axis_read_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]         m_axis_read_desc_ram_addr,
  output logic [DMA_LEN_WIDTH-1:0]          m_axis_read_desc_len,
  output logic [M_TAG_WIDTH-1:0]            m_axis_read_desc_tag,
  output logic                              m_axis_read_desc_valid,
  input  logic                              m_axis_read_desc_ready,

  input  logic [M_TAG_WIDTH-1:0]            s_axis_read_desc_status_tag,
  input  logic [3:0]                        s_axis_read_desc_status_error,
  input  logic                              s_axis_read_desc_status_valid,

  output logic                              busy
`ifdef PSPIN_HOSTMEM_DMA_RD_ARB_STATS_EN
  ,
  output logic [PORTS*32-1:0]               stat_issued,
  output logic [31:0]                       stat_err,
  output logic [31:0]                       stat_drop
`endif
);

  localparam int SW = slot_idx_width(MAX_OUTSTANDING);
  localparam int PW = $clog2(PORTS);

  logic [MAX_OUTSTANDING-1:0] free_map;
  slot_entry_t                slot_tbl [MAX_OUTSTANDING];

  logic [SW-1:0]              alloc_idx;
  logic                       grant_en;
  logic [PORTS-1:0]           grant;
  logic [PW-1:0]              grant_idx;
  logic                       grant_valid;

  logic [SW-1:0]              st_idx;
  logic                       st_hit;
  logic [PW-1:0]              st_port;

  logic [MAX_OUTSTANDING-1:0] free_nxt;
  logic                       m_valid_nxt;

  always_comb begin
    alloc_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (free_map[i]) alloc_idx = SW'(i);
    end
  end

  assign grant_en = (|free_map) && (!m_axis_read_desc_valid || m_axis_read_desc_ready);

  pspin_rr_arbiter #(
    .PORTS (PORTS)
  ) u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .req         (s_axis_read_desc_valid),
    .en          (grant_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign s_axis_read_desc_ready = grant;

  // Statuses with tag bits beyond the slot index, or for idle slots, are stale and ignored.
  assign st_idx  = s_axis_read_desc_status_tag[SW-1:0];
  assign st_hit  = s_axis_read_desc_status_valid
                 && ((s_axis_read_desc_status_tag >> SW) == '0)
                 && slot_tbl[st_idx].valid;
  assign st_port = slot_tbl[st_idx].port[PW-1:0];

  always_comb begin
    free_nxt = free_map;
    if (grant_valid) free_nxt[alloc_idx] = 1'b0;
    if (st_hit)      free_nxt[st_idx]    = 1'b1;
  end

  assign m_valid_nxt = grant_valid || (m_axis_read_desc_valid && !m_axis_read_desc_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      free_map                      <= '1;
      for (int i = 0; i < MAX_OUTSTANDING; i++) slot_tbl[i] <= '0;
      m_axis_read_desc_dma_addr     <= '0;
      m_axis_read_desc_ram_sel      <= '0;
      m_axis_read_desc_ram_addr     <= '0;
      m_axis_read_desc_len          <= '0;
      m_axis_read_desc_tag          <= '0;
      m_axis_read_desc_valid        <= 1'b0;
      m_axis_read_desc_status_tag   <= '0;
      m_axis_read_desc_status_error <= '0;
      m_axis_read_desc_status_valid <= '0;
      busy                          <= 1'b0;
    end else begin
      free_map               <= free_nxt;
      m_axis_read_desc_valid <= m_valid_nxt;
      busy                   <= (free_nxt != '1) || m_valid_nxt;

      if (grant_valid) begin
        slot_tbl[alloc_idx].port  <= PORT_IDX_WIDTH'(grant_idx);
        slot_tbl[alloc_idx].s_tag <= S_TAG_MAX_WIDTH'(s_axis_read_desc_tag[grant_idx*S_TAG_WIDTH +: S_TAG_WIDTH]);
        slot_tbl[alloc_idx].valid <= 1'b1;
        m_axis_read_desc_dma_addr <= s_axis_read_desc_dma_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        m_axis_read_desc_ram_sel  <= s_axis_read_desc_ram_sel[grant_idx*RAM_SEL_WIDTH +: RAM_SEL_WIDTH];
        m_axis_read_desc_ram_addr <= s_axis_read_desc_ram_addr[grant_idx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
        m_axis_read_desc_len      <= s_axis_read_desc_len[grant_idx*DMA_LEN_WIDTH +: DMA_LEN_WIDTH];
        m_axis_read_desc_tag      <= M_TAG_WIDTH'(alloc_idx);
      end

      m_axis_read_desc_status_valid <= '0;
      if (st_hit) begin
        slot_tbl[st_idx].valid                                      <= 1'b0;
        m_axis_read_desc_status_valid[st_port]                      <= 1'b1;
        m_axis_read_desc_status_tag[st_port*S_TAG_WIDTH +: S_TAG_WIDTH] <= slot_tbl[st_idx].s_tag[S_TAG_WIDTH-1:0];
        m_axis_read_desc_status_error[st_port*4 +: 4]               <= s_axis_read_desc_status_error;
      end
    end
  end

`ifdef PSPIN_HOSTMEM_DMA_RD_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_issued <= '0;
      stat_err    <= '0;
      stat_drop   <= '0;
    end else begin
      if (grant_valid && (stat_issued[grant_idx*32 +: 32] != '1)) begin
        stat_issued[grant_idx*32 +: 32] <= stat_issued[grant_idx*32 +: 32] + 32'd1;
      end
      if (st_hit && (s_axis_read_desc_status_error != DMA_ERR_NONE) && (stat_err != '1)) begin
        stat_err <= stat_err + 32'd1;
      end
      if (s_axis_read_desc_status_valid && !st_hit && (stat_drop != '1)) begin
        stat_drop <= stat_drop + 32'd1;
      end
    end
  end
`endif

endmodule
